arith_op_responder: RTL and testbench
=====================================

# arith_op_responder

Responder side of the arithmetic sequencing scheme: accepts one operation request at a time over a valid/ready channel, executes it, and returns the result over a second valid/ready channel. Opcodes are SUM, MULT, DIV and EXT, with IDLE as a no-op. A sequencer FSM offloads its arithmetic here instead of computing inline. Division is a multi-cycle serial restoring divider; all other operations complete in one cycle.

## Interface
- WIDTH, 32, operand and result width in bits (≥2).
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_op  input  3  opcode from arith_op_pkg.
- req_a  input  WIDTH  first operand (minuend, dividend).
- req_b  input  WIDTH  second operand (subtrahend, divisor).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  WIDTH  result.
- rsp_err  output  1  divide-by-zero or illegal opcode.
- op_count  output  32  completed responses; wraps modulo 2^32.

## Operation
- Opcodes:
  - OP_IDLE=000: no-op, result 0.
  - OP_SUM=001: a+b.
  - OP_MULT=010: a*b.
  - OP_DIV=011: a/b, unsigned quotient.
  - OP_EXT=100: a−b.
  - 101–111: illegal.
- Width rules: all results are the low WIDTH bits.
  - SUM wraps.
  - MULT truncates the 2·WIDTH product.
  - EXT wraps (two's complement).
  - DIV quotient is exact; remainder is discarded.
- Error cases:
  - DIV with b=0: rsp_data all-ones, rsp_err=1, no iteration.
  - Illegal opcode: rsp_data 0, rsp_err=1.
  - All other cases: rsp_err=0.
- FSM states and transitions:
  - S_IDLE: req_ready=1. On handshake with op=DIV and b≠0, go to S_DIV. On any other handshake, register the result and go to S_RESP.
  - S_DIV: one quotient bit per cycle for WIDTH cycles, MSB first. Then register the quotient and go to S_RESP.
  - S_RESP: rsp_valid=1. On rsp_valid&&rsp_ready, increment op_count and go to S_IDLE.
- req_ready is high only in S_IDLE. No request is accepted in the same cycle as a response handshake.
- Backpressure: rsp_data and rsp_err hold stable while rsp_valid=1 and rsp_ready=0.
- Operands are captured at request handshake; later changes on req_a, req_b and req_op have no effect.

## Timing
- Reset values: state S_IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, op_count=0. Divider registers are cleared.
- Reset mid-operation: an in-flight DIV or pending response is discarded, and op_count returns to 0.
- Request handshake occurs on rising edge E0.
- Non-DIV latency: rsp_valid is high in the cycle after E0. This also applies to DIV with b=0.
- DIV latency: rsp_valid is high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles after acceptance.
- Response handshake occurs on edge R:
  - rsp_valid drops after R.
  - op_count increments at R.
  - req_ready rises after R.
- Throughput, assuming rsp_ready held high:
  - One non-DIV operation per 2 cycles.
  - One DIV per WIDTH+2 cycles.
- No combinational path from req_* to rsp_*, or from rsp_ready to req_ready.

## Structure
- arith_op_pkg holds:
  - The opcode constants OP_IDLE, OP_SUM, OP_MULT, OP_DIV and OP_EXT, with the same 3-bit encoding as the sequencer state values.
  - The responder state enum.
- One sub-module: arith_serial_div.
  - Parameter: WIDTH.
  - Ports: start, dividend, divisor, done, quotient.
  - Runs the restoring shift/subtract iteration and its bit counter.
- The top level holds:
  - The handshake FSM.
  - Single-cycle SUM, MULT and EXT datapaths.
  - Error decode.
  - op_count.

## Test plan
- Sequencer mirror chain, with rsp_ready held high:
  - SUM a=2,b=3 → 5.
  - MULT a=2,b=5 → 10.
  - DIV a=10,b=5 → 2, with rsp_valid exactly 33 cycles after acceptance.
  - EXT a=5,b=2 → 3.
  - All with rsp_err=0; op_count=4 at the end.
- Wrap and truncation:
  - SUM 0xFFFFFFFF+1 → 0.
  - MULT 0x10000*0x10000 → 0.
  - EXT 0−1 → 0xFFFFFFFF.
- Error responses, each with rsp_err=1 and one-cycle latency:
  - DIV a=7,b=0 → 0xFFFFFFFF.
  - op=101 → 0.
- Backpressure:
  - Set rsp_ready=0 for 5 cycles after a SUM 4+4.
  - rsp_data holds 8, req_ready stays 0, and a req_valid held high is not accepted until the cycle after the response handshake.
- Reset mid-operation:
  - Assert rst 10 cycles into DIV 100/7.
  - Response is never delivered; outputs take their reset values; op_count=0.
  - A following DIV 100/7 → 14.

Source files
------------

// File: rtl/arith_op_pkg.sv
// Opcode encodings and responder state
// shared by the arithmetic responder.
package arith_op_pkg;

  localparam logic [2:0] OP_IDLE = 3'b000;
  localparam logic [2:0] OP_SUM  = 3'b001;
  localparam logic [2:0] OP_MULT = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_EXT  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_RESP = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/arith_serial_div.sv
// Serial restoring divider, one quotient
// bit per cycle, MSB first.
module arith_serial_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign fits    = ~trial[WIDTH];
  assign rem_nxt = fits ? trial[WIDTH-1:0]
                        : shifted[WIDTH-1:0];
  assign quo_nxt = {quo_q[WIDTH-2:0], fits};

  // done flags the cycle whose edge lands the
  // last bit; quotient is that post-step value
  assign done     = busy_q && (cnt_q == CW'(1));
  assign quotient = quo_nxt;

  // Load operands on start, then iterate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= CW'(WIDTH);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= rem_nxt;
      quo_q  <= quo_nxt;
      cnt_q  <= cnt_q - CW'(1);
      busy_q <= (cnt_q != CW'(1));
    end
  end

endmodule

// File: rtl/arith_op_responder.sv
// Arithmetic responder: request/response
// handshake FSM around SUM/MULT/DIV/EXT.
module arith_op_responder
  import arith_op_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [31:0]      op_count
);

  rsp_state_e       state;
  logic [WIDTH-1:0] data_q;
  logic             err_q;
  logic [WIDTH-1:0] res;
  logic             res_err;
  logic             req_fire;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign req_fire  = req_valid && req_ready;
  assign div_start = req_fire
                  && (req_op == OP_DIV)
                  && (req_b != '0);

  arith_serial_div #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (req_a),
    .divisor  (req_b),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Single-cycle results and error decode;
  // the DIV arm only matters for b == 0
  always_comb begin
    res     = '0;
    res_err = 1'b0;
    unique case (1'b1)
      (req_op == OP_IDLE): res = '0;
      (req_op == OP_SUM):  res = req_a + req_b;
      (req_op == OP_MULT): res = req_a * req_b;
      (req_op == OP_EXT):  res = req_a - req_b;
      (req_op == OP_DIV): begin
        res     = '1;
        res_err = 1'b1;
      end
      default: res_err = 1'b1;
    endcase
  end

  // Handshake FSM with registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      data_q   <= '0;
      err_q    <= 1'b0;
      op_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_fire) begin
            if (div_start) begin
              state <= S_DIV;
            end else begin
              data_q <= res;
              err_q  <= res_err;
              state  <= S_RESP;
            end
          end
        end
        S_DIV: begin
          if (div_done) begin
            data_q <= div_quo;
            err_q  <= 1'b0;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            op_count <= op_count + 32'd1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_op_responder.sv
// Directed self-checking bench for
// arith_op_responder.
module tb_arith_op_responder;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_err;
  logic [31:0]   op_count;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_cnt = 0;

  always #5 clk = ~clk;

  arith_op_responder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .op_count  (op_count)
  );

  // Handshake on the next edge, then scramble
  // the request inputs to prove capture.
  task automatic issue(input logic [2:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 3'b010;
    req_a = 32'hDEAD_BEEF;
    req_b = 32'h0000_0003;
  endtask

  // Edges after acceptance until rsp_valid
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 3'b000;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 100",
               {req_ready, rsp_valid, rsp_err});
    end
    vectors++;
    if (rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", rsp_data);
    end
    vectors++;
    if (op_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", op_count);
    end
  endtask

  // Issue one op with rsp_ready high and check
  // latency, data, error and release.
  task automatic run_op(input string nm,
                        input logic [2:0] op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] ed,
                        input logic ee,
                        input int elat);
    int lat;
    issue(op, a, b);
    wait_rsp(lat);
    vectors++;
    if (lat !== elat) begin
      errors++;
      $display("FAIL %s_lat: got %0d want %0d", nm, lat, elat);
    end
    vectors++;
    if (rsp_data !== ed) begin
      errors++;
      $display("FAIL %s_data: got %h want %h", nm, rsp_data, ed);
    end
    vectors++;
    if (rsp_err !== ee) begin
      errors++;
      $display("FAIL %s_err: got %b want %b", nm, rsp_err, ee);
    end
    @(posedge clk);
    #1;
    exp_cnt++;
    vectors++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL %s_release: got %b want 01",
               nm, {rsp_valid, req_ready});
    end
  endtask

  task automatic test_chain;
    run_op("sum", 3'b001, 2, 3, 5, 1'b0, 0);
    run_op("mult", 3'b010, 2, 5, 10, 1'b0, 0);
    run_op("div", 3'b011, 10, 5, 2, 1'b0, W);
    run_op("ext", 3'b100, 5, 2, 3, 1'b0, 0);
    vectors++;
    if (op_count !== 32'd4) begin
      errors++;
      $display("FAIL chain_cnt: got %0d want 4", op_count);
    end
  endtask

  task automatic test_wrap;
    run_op("sum_wrap", 3'b001, 32'hFFFF_FFFF, 1, 0, 1'b0, 0);
    run_op("mult_trunc", 3'b010, 32'h1_0000, 32'h1_0000,
           0, 1'b0, 0);
    run_op("ext_wrap", 3'b100, 0, 1, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("idle", 3'b000, 9, 9, 0, 1'b0, 0);
  endtask

  task automatic test_errors;
    run_op("div0", 3'b011, 7, 0, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("illegal", 3'b101, 7, 3, 0, 1'b1, 0);
    run_op("illegal7", 3'b111, 1, 1, 0, 1'b1, 0);
    vectors++;
    if (op_count !== exp_cnt) begin
      errors++;
      $display("FAIL err_cnt: got %0d want %0d", op_count, exp_cnt);
    end
  endtask

  task automatic test_backpressure;
    int bad = 0;
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(3'b001, 4, 4);
    req_valid = 1'b1;
    req_op = 3'b001;
    req_a = 1;
    req_b = 1;
    for (int i = 0; i < 5; i++) begin
      if (!rsp_valid || rsp_data !== 32'd8 || req_ready)
        bad++;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
    end
    rsp_ready = 1'b1;
    vectors++;
    if ({rsp_valid, rsp_data} !== {1'b1, 32'd8}) begin
      errors++;
      $display("FAIL bp_data: got %b/%h want 1/8",
               rsp_valid, rsp_data);
    end
    @(posedge clk);
    #1;
    exp_cnt++;
    vectors++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: got %b want 01",
               {rsp_valid, req_ready});
    end
    vectors++;
    if (op_count !== exp_cnt) begin
      errors++;
      $display("FAIL bp_cnt: got %0d want %0d", op_count, exp_cnt);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    vectors++;
    if ({rsp_valid, rsp_data} !== {1'b1, 32'd2}) begin
      errors++;
      $display("FAIL bp_next: got %b/%h want 1/2",
               rsp_valid, rsp_data);
    end
    @(posedge clk);
    #1;
    exp_cnt++;
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    issue(3'b011, 100, 7);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_err, rsp_data}
        !== {3'b100, 32'h0}) begin
      errors++;
      $display("FAIL mid_reset_out: got %b/%h want 100/0",
               {req_ready, rsp_valid, rsp_err}, rsp_data);
    end
    vectors++;
    if (op_count !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_cnt: got %0d want 0", op_count);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_no_rsp: got %0d valid cycles want 0", seen);
    end
    run_op("div_after", 3'b011, 100, 7, 14, 1'b0, W);
    vectors++;
    if (op_count !== 32'd1) begin
      errors++;
      $display("FAIL mid_cnt: got %0d want 1", op_count);
    end
  endtask

  initial begin
    test_reset;
    test_chain;
    test_wrap;
    test_errors;
    test_backpressure;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
